// File: rtl/bid_arb_pkg.sv
// bid_arb_pkg: shared defaults, saturating credit arithmetic and round-robin search for bid_arbiter
// Contents: default parameter constants, bal_sat_add/bal_sat_sub, rr_first
package bid_arb_pkg;

    localparam int N_MASTERS_DEF     = 4;
    localparam int BID_W_DEF         = 4;
    localparam int BAL_W_DEF         = 10;
    localparam int BAL_INIT_DEF      = 750;
    localparam int REFILL_PERIOD_DEF = 400;
    localparam int REFILL_AMT_DEF    = 750;
    localparam int BAL_MAX_DEF       = 900;
    localparam int STARVE_LIMIT_DEF  = 60;

    function automatic logic [31:0] bal_sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a - b : 32'd0;
    endfunction

    // Operands are at most BAL_W bits, so the 32-bit sum cannot overflow.
    function automatic logic [31:0] bal_sat_add(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] max);
        logic [31:0] sum;
        sum = a + b;
        return (sum > max) ? max : sum;
    endfunction

    // Returns {found, index} of the first set bit of mask searching upward from ptr+1, wrapping at n.
    // Scanning from the farthest candidate down lets the nearest hit overwrite earlier ones.
    function automatic logic [4:0] rr_first(input logic [15:0] mask, input logic [3:0] ptr, input int n);
        logic [4:0] r;
        int p;
        r = '0;
        for (int k = 16; k >= 1; k--) begin
            p = int'(ptr) + k;
            if (p >= n) p = p - n;
            if (k <= n && mask[p]) r = {1'b1, 4'(p)};
        end
        return r;
    endfunction

endpackage

// File: rtl/bid_credit_acct.sv
// bid_credit_acct: per-master credit balance with debit/refill and optional starvation counter
// Ports: clk, rst (async, active-high), bid, granted (decision for this edge), refill_tick,
//        balance (current credit), starve (counter reached STARVE_LIMIT; 0 unless STARVE_GUARD_EN)
// Configuration macro: STARVE_GUARD_EN builds the starvation counter.
module bid_credit_acct
    import bid_arb_pkg::*;
#(
    parameter int BID_W        = BID_W_DEF,
    parameter int BAL_W        = BAL_W_DEF,
    parameter int BAL_INIT     = BAL_INIT_DEF,
    parameter int REFILL_AMT   = REFILL_AMT_DEF,
`ifdef STARVE_GUARD_EN
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
`endif
    parameter int BAL_MAX      = BAL_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BID_W-1:0] bid,
    input  logic             granted,
    input  logic             refill_tick,
    output logic [BAL_W-1:0] balance,
    output logic             starve
);

    logic [BAL_W-1:0] debited;

    assign debited = granted ? BAL_W'(bal_sat_sub(32'(balance), 32'(bid))) : balance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) balance <= BAL_W'(BAL_INIT);
        else     balance <= refill_tick ? BAL_W'(bal_sat_add(32'(debited), 32'(REFILL_AMT), 32'(BAL_MAX))) : debited;
    end

`ifdef STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            cnt <= '0;
        else if (granted || bid == '0)      cnt <= '0;
        else if (cnt != CW'(STARVE_LIMIT))  cnt <= cnt + CW'(1);
    end
    assign starve = cnt == CW'(STARVE_LIMIT);
`else
    assign starve = 1'b0;
`endif

endmodule

// File: rtl/bid_arbiter.sv
// bid_arbiter: credit-weighted N-master bus arbiter with round-robin tie break and starvation guard
// Ports: clk, rst (async, active-high), bid (packed per-master bids, 0 = idle),
//        grant (registered one-hot), grant_valid, grant_id, balance (packed balances), starve
// Configuration macro: STARVE_GUARD_EN enables forced service of starved requesters.
module bid_arbiter
    import bid_arb_pkg::*;
#(
    parameter  int N_MASTERS     = N_MASTERS_DEF,
    parameter  int BID_W         = BID_W_DEF,
    parameter  int BAL_W         = BAL_W_DEF,
    parameter  int BAL_INIT      = BAL_INIT_DEF,
    parameter  int REFILL_PERIOD = REFILL_PERIOD_DEF,
    parameter  int REFILL_AMT    = REFILL_AMT_DEF,
    parameter  int BAL_MAX       = BAL_MAX_DEF,
    parameter  int STARVE_LIMIT  = STARVE_LIMIT_DEF,
    localparam int IW            = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS*BID_W-1:0] bid,
    output logic [N_MASTERS-1:0]       grant,
    output logic                       grant_valid,
    output logic [IW-1:0]              grant_id,
    output logic [N_MASTERS*BAL_W-1:0] balance,
    output logic [N_MASTERS-1:0]       starve
);

    localparam int RW = (REFILL_PERIOD > 2) ? $clog2(REFILL_PERIOD) : 1;

    if (BAL_MAX >= 2 ** BAL_W || BID_W > BAL_W || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("bid_arbiter: inconsistent configuration");
    end

    logic [BID_W-1:0]     b   [N_MASTERS];
    logic [BAL_W-1:0]     bal [N_MASTERS];
    logic [N_MASTERS-1:0] elig, starved, top, nxt;
    logic [BID_W-1:0]     max_bid;
    logic [4:0]           pick;
    logic [IW-1:0]        ptr;
    logic [RW-1:0]        rcnt;
    logic                 refill_tick;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        assign b[i]       = bid[i*BID_W +: BID_W];
        assign elig[i]    = b[i] != '0 && bal[i] >= BAL_W'(b[i]);
        assign starved[i] = b[i] != '0 && starve[i];
        assign top[i]     = elig[i] && b[i] == max_bid;
        assign balance[i*BAL_W +: BAL_W] = bal[i];
        bid_credit_acct #(
            .BID_W        (BID_W),
            .BAL_W        (BAL_W),
            .BAL_INIT     (BAL_INIT),
            .REFILL_AMT   (REFILL_AMT),
`ifdef STARVE_GUARD_EN
            .STARVE_LIMIT (STARVE_LIMIT),
`endif
            .BAL_MAX      (BAL_MAX)
        ) u_acct (
            .clk         (clk),
            .rst         (rst),
            .bid         (b[i]),
            .granted     (nxt[i]),
            .refill_tick (refill_tick),
            .balance     (bal[i]),
            .starve      (starve[i])
        );
    end

    always_comb begin
        max_bid = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (elig[i] && b[i] > max_bid) max_bid = b[i];
    end

    // Starved requesters pre-empt bidding; top is empty when nobody is eligible, so pick then finds nothing.
    assign pick        = |starved ? rr_first(16'(starved), 4'(ptr), N_MASTERS)
                                  : rr_first(16'(top), 4'(ptr), N_MASTERS);
    assign nxt         = pick[4] ? N_MASTERS'(1) << pick[3:0] : '0;
    assign refill_tick = rcnt == RW'(REFILL_PERIOD - 1);
    assign grant_valid = |grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            grant_id <= '0;
            ptr      <= IW'(N_MASTERS - 1);
            rcnt     <= '0;
        end else begin
            grant    <= nxt;
            grant_id <= pick[4] ? IW'(pick[3:0]) : '0;
            if (pick[4]) ptr <= IW'(pick[3:0]);
            rcnt     <= refill_tick ? '0 : rcnt + RW'(1);
        end
    end

endmodule
